// File: rtl/decode_stage.sv
// Single-entry decode / operand-fetch stage: holds one instruction, decodes fields and
// immediate, and forwards writebacks around the registered-read register file.
// Optional illegal-opcode flag on ex_illegal is enabled by defining DECODE_ILLEGAL_EN.
module decode_stage #(
  parameter int                XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic [4:0]      rf_read_addr1,
  output logic [4:0]      rf_read_addr2,
  input  logic [XLEN-1:0] rf_read_data1,
  input  logic [XLEN-1:0] rf_read_data2,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rd,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7b5
`ifdef DECODE_ILLEGAL_EN
  ,
  output logic            ex_illegal
`endif
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] pc_q;
  logic            last_wb_en;
  logic [4:0]      last_wb_addr;
  logic [XLEN-1:0] last_wb_data;
  logic            accept;

  // Handshake: if_ready = EMPTY | ex_ready; a transfer happens on if_valid & if_ready,
  // except that flush vetoes it. ex_valid holds until ex_ready is seen high.
  assign accept = if_valid & if_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush)                          state_d = EMPTY;
    else if (accept)                    state_d = FULL;
    else if (state_q == FULL && ex_ready) state_d = EMPTY;
  end

  always_comb begin
    ex_valid = (state_q == FULL);
    if_ready = (state_q == EMPTY) | ex_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q      <= NOP;
      pc_q         <= RESET_PC;
      last_wb_en   <= 1'b0;
      last_wb_addr <= 5'd0;
      last_wb_data <= '0;
    end else begin
      if (accept) begin
        instr_q <= if_instr;
        pc_q    <= if_pc;
      end
      // Mirrors the write the register file commits at the same edge as its read.
      last_wb_en   <= wb_en;
      last_wb_addr <= wb_addr;
      last_wb_data <= wb_data;
    end
  end

  // A stalled instruction re-reads its own sources so late writes land via the file.
  always_comb begin
    if (accept) begin
      rf_read_addr1 = if_instr[19:15];
      rf_read_addr2 = if_instr[24:20];
    end else begin
      rf_read_addr1 = instr_q[19:15];
      rf_read_addr2 = instr_q[24:20];
    end
  end

  function automatic logic [XLEN-1:0] operand(
    input logic [4:0]      rs,
    input logic [XLEN-1:0] rf_data,
    input logic            cur_en,
    input logic [4:0]      cur_addr,
    input logic [XLEN-1:0] cur_data,
    input logic            old_en,
    input logic [4:0]      old_addr,
    input logic [XLEN-1:0] old_data
  );
    if (rs == 5'd0)                      return '0;
    else if (cur_en && cur_addr == rs)   return cur_data;
    else if (old_en && old_addr == rs)   return old_data;
    else                                 return rf_data;
  endfunction

  function automatic logic [31:0] imm_gen(input logic [31:0] i);
    case (i[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011:
        return {{20{i[31]}}, i[31:20]};
      7'b0100011:
        return {{20{i[31]}}, i[31:25], i[11:7]};
      7'b1100011:
        return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      7'b0110111, 7'b0010111:
        return {i[31:12], 12'h000};
      7'b1101111:
        return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default:
        return 32'h0000_0000;
    endcase
  endfunction

  always_comb begin
    ex_pc       = pc_q;
    ex_imm      = imm_gen(instr_q);
    ex_rd       = instr_q[11:7];
    ex_opcode   = instr_q[6:0];
    ex_funct3   = instr_q[14:12];
    ex_funct7b5 = instr_q[30];
    ex_rs1_data = operand(instr_q[19:15], rf_read_data1, wb_en, wb_addr, wb_data,
                          last_wb_en, last_wb_addr, last_wb_data);
    ex_rs2_data = operand(instr_q[24:20], rf_read_data2, wb_en, wb_addr, wb_data,
                          last_wb_en, last_wb_addr, last_wb_data);
  end

`ifdef DECODE_ILLEGAL_EN
  always_comb begin
    ex_illegal = 1'b1;
    if (instr_q[1:0] == 2'b11) begin
      case (instr_q[6:0])
        7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111,
        7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011, 7'b0001111:
          ex_illegal = 1'b0;
        default:
          ex_illegal = 1'b1;
      endcase
    end
  end
`endif

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Single-entry decode/operand-fetch stage of the Eka v1 core. Sits between fetch and execute.
- Accepts instructions over a valid/ready handshake and drives the read ports of the 32x32 register file, which has registered reads (1-cycle latency, write-then-read not visible at the same edge).
- Decodes fields and immediate, then presents operands to execute.
- Forwards in-flight writebacks so operands are correct despite the register file's read latency.

Parameters:
XLEN, 32, data/PC width (only 32 supported)
RESET_PC, 32'h0000_0000, value of ex_pc after reset

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  discard held instruction (branch/jump redirect)
if_valid  input  1  fetch presents instruction
if_ready  output  1  stage can accept this cycle
if_instr  input  32  instruction word
if_pc  input  32  instruction address
rf_read_addr1  output  5  to register file read port 1
rf_read_addr2  output  5  to register file read port 2
rf_read_data1  input  32  register file data, 1 cycle after address
rf_read_data2  input  32  register file data, 1 cycle after address
wb_en  input  1  writeback write enable (same net as register file write_en)
wb_addr  input  5  writeback destination
wb_data  input  32  writeback data
ex_valid  output  1  held instruction valid to execute
ex_ready  input  1  execute accepts
ex_pc  output  32  PC of held instruction
ex_rs1_data  output  32  operand 1 after bypass
ex_rs2_data  output  32  operand 2 after bypass
ex_imm  output  32  sign-extended immediate
ex_rd  output  5  destination register
ex_opcode  output  7  instr[6:0]
ex_funct3  output  3  instr[14:12]
ex_funct7b5  output  1  instr[30]

Behaviour:
- State: EMPTY or FULL. Storage: held instr, held pc, last_wb_en/addr/data.
- Reset (async, rst_n=0):
  - state EMPTY, ex_valid=0.
  - held instr=32'h0000_0013 (NOP), ex_pc=RESET_PC.
  - last_wb_en=0.
  - All decoded outputs derive from the NOP: ex_rd=0, ex_imm=0.
- if_ready = (state==EMPTY) | ex_ready.
- accept = if_valid & if_ready & ~flush.
- ex_valid = (state==FULL).
- Transitions at each edge:
  - flush=1 -> EMPTY. Flush has priority over both accept and retire.
  - accept -> FULL, load instr/pc.
  - FULL & ex_ready & ~accept -> EMPTY.
  - Otherwise hold.
- Read address mux, combinational:
  - if accept: rf_read_addrN = if_instr rs fields ([19:15], [24:20]).
  - else: rs fields of the held instr.
  - The held instruction is therefore re-read every cycle it stalls.
- last_wb registers sample wb_en/wb_addr/wb_data every edge. They cover the write the register file performed at the same edge as its read.
- Operand N, priority order:
  1. rs==0 -> 32'h0. Register file x0 is not reset; never trust it.
  2. wb_en & wb_addr==rs -> wb_data (write happening this cycle).
  3. last_wb_en & last_wb_addr==rs -> last_wb_data.
  4. Otherwise rf_read_dataN.
- Immediate by opcode:
  - I (0000011, 0010011, 1100111, 1110011): {20{i[31]}, i[31:20]}.
  - S (0100011): {20{i[31]}, i[31:25], i[11:7]}.
  - B (1100011): {19{i[31]}, i[31], i[7], i[30:25], i[11:8], 0}.
  - U (0110111, 0010111): {i[31:12], 12'h0}.
  - J (1101111): {11{i[31]}, i[31], i[19:12], i[20], i[30:21], 0}.
  - Others: 0.
- ex_* outputs are stable while ex_valid & ~ex_ready. Operands may update only through bypass.
- Simultaneous retire and accept while FULL: new instruction is loaded with no bubble.
- rst_n deasserted mid-stall: state returns to EMPTY; downstream sees ex_valid=0 asynchronously.

Optional Feature:
- Macro DECODE_ILLEGAL_EN.
- When defined:
  - Extra output port ex_illegal (1 bit), reset 0.
  - Asserted with the held instruction when opcode is not one of 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 1110011, 0001111, or when instr[1:0] != 2'b11.
  - The instruction still passes through normally.
- When undefined: port absent; no checking logic.

Test Plan:
- Reset with rst_n=0 mid-stream -> ex_valid=0 immediately; after release ex_pc=RESET_PC; if_ready=1.
- Accept addi x5,x0,-1 (32'hFFF00293) -> next cycle ex_valid=1, ex_imm=32'hFFFF_FFFF, ex_rd=5, ex_rs1_data=0 even with rf_read_data1=32'hDEAD_BEEF.
- Writeback x7=0x1234 at the accept edge, then add x8,x7,x7 -> ex_rs1_data=ex_rs2_data=0x1234 while the register file returns a stale 0.
- Hold ex_ready=0 for 3 cycles with wb x7=0x55 in cycle 2 -> operand updates to 0x55; all other ex_* outputs unchanged; if_ready=0.
- FULL with ex_ready=1, if_valid=1, flush=1 -> next cycle ex_valid=0 and the new instruction is discarded.
- Back-to-back stream of 4 instructions with ex_ready=1 -> one per cycle, no bubbles, correct B/J/S/U immediates (e.g. jal x1,+2048 -> ex_imm=32'h0000_0800).
